// File: rtl/fifo_v4_pkg.sv
// -----------------------------------------------------------------------------
// fifo_v4_pkg
//   Shared constants and width helpers for the fifo_v4 FIFO.
//   - FIFO_V4_AE_THRESH_DEF / FIFO_V4_AF_THRESH_DEF : default threshold levels
//   - ptr_width()   : pointer width for a given depth ($clog2, minimum 1)
//   - usage_width() : width of the occupancy count (holds 0..DEPTH)
// -----------------------------------------------------------------------------
package fifo_v4_pkg;

   localparam int unsigned FIFO_V4_AE_THRESH_DEF = 128;
   localparam int unsigned FIFO_V4_AF_THRESH_DEF = 128;

   function automatic int unsigned ptr_width(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   // One extra bit so the count can represent a completely full FIFO.
   function automatic int unsigned usage_width(input int unsigned depth);
      return ptr_width(depth) + 1;
   endfunction

endpackage

// File: rtl/fifo_v4_ram.sv
// -----------------------------------------------------------------------------
// fifo_v4_ram
//   Simple dual-port storage for fifo_v4: one write port, one synchronous read
//   port, no reset on the array or read register, so it maps onto block RAM.
//   Ports:
//     clk_i    : clock
//     wr_en    : write strobe
//     wr_addr  : write address
//     wr_data  : write data
//     rd_en    : read strobe (read register holds its value when low)
//     rd_addr  : read address
//     rd_data  : registered read data, valid the cycle after rd_en
// -----------------------------------------------------------------------------
module fifo_v4_ram
   import fifo_v4_pkg::*;
#(
   parameter int unsigned DEPTH  = 512,
   parameter type         dtype  = logic [31:0],
   parameter int unsigned ADDR_W = ptr_width(DEPTH)
) (
   input  logic              clk_i,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  dtype              wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output dtype              rd_data
);

   dtype mem [0:DEPTH-1];

   always_ff @(posedge clk_i) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/fifo_v4.sv
// -----------------------------------------------------------------------------
// fifo_v4
//   Single-clock first-word-fall-through FIFO built on a synchronous-read RAM.
//   The RAM read register acts as the head of the queue, so data_o is valid
//   whenever empty_o is low. Occupancy, thresholds and sticky error flags are
//   registered.
//   Optional feature macro: FIFO_V4_BYPASS_EN -- a push into a FIFO holding no
//   entries is loaded straight into a bypass head register (1-cycle latency)
//   instead of going through the RAM.
//   Ports:
//     clk_i, rst_i    : clock, synchronous active-high reset
//     flush_i         : synchronous flush (drops contents, keeps error flags)
//     data_i, push_i  : write side
//     data_o, pop_i   : read side, data_o is the head entry
//     full_o, empty_o : usage_o == DEPTH / head not valid
//     almost_full_o   : usage_o >= DEPTH - AF_THRESH
//     almost_empty_o  : usage_o <= AE_THRESH
//     usage_o         : accepted and not yet popped entries
//     overflow_o      : sticky, push attempted while full
//     underflow_o     : sticky, pop attempted while empty
// -----------------------------------------------------------------------------
module fifo_v4
   import fifo_v4_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DEPTH      = 512,
   parameter type         dtype      = logic [DATA_WIDTH-1:0],
   parameter int unsigned AE_THRESH  = FIFO_V4_AE_THRESH_DEF,
   parameter int unsigned AF_THRESH  = FIFO_V4_AF_THRESH_DEF,
   parameter int unsigned ADDR_DEPTH = ptr_width(DEPTH)
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                flush_i,
   input  dtype                data_i,
   input  logic                push_i,
   output dtype                data_o,
   input  logic                pop_i,
   output logic                full_o,
   output logic                empty_o,
   output logic                almost_full_o,
   output logic                almost_empty_o,
   output logic [ADDR_DEPTH:0] usage_o,
   output logic                overflow_o,
   output logic                underflow_o
);

   localparam logic [ADDR_DEPTH-1:0] PTR_ONE  = ADDR_DEPTH'(1);
   localparam logic [ADDR_DEPTH:0]   CNT_ONE  = (ADDR_DEPTH+1)'(1);
   localparam logic [ADDR_DEPTH:0]   CNT_FULL = (ADDR_DEPTH+1)'(DEPTH);

   function automatic logic is_almost_empty(input logic [ADDR_DEPTH:0] cnt);
      return int'(cnt) <= int'(AE_THRESH);
   endfunction

   // Signed compare so AF_THRESH >= DEPTH simply keeps the flag asserted.
   function automatic logic is_almost_full(input logic [ADDR_DEPTH:0] cnt);
      return int'(cnt) >= (int'(DEPTH) - int'(AF_THRESH));
   endfunction

   logic [ADDR_DEPTH-1:0] wr_ptr_q, wr_ptr_nxt;
   logic [ADDR_DEPTH-1:0] rd_ptr_q, rd_ptr_nxt;
   logic [ADDR_DEPTH-1:0] rd_addr;
   logic [ADDR_DEPTH:0]   usage_q, usage_nxt;
   logic [ADDR_DEPTH:0]   ram_cnt, ram_avail;
   logic                  full_q, ae_q, af_q, ovf_q, unf_q;
   logic                  ram_vld_p1, ram_vld_nxt;
   logic                  byp_vld_p1;
   dtype                  ram_rdata_p1;
   dtype                  byp_data_p1;
   logic                  head_vld;
   logic                  push_acc, pop_acc, pop_ram, byp_take;
   logic                  wr_en, rd_en;

   assign head_vld = ram_vld_p1 | byp_vld_p1;
   assign push_acc = push_i & ~full_q & ~flush_i;
   assign pop_acc  = pop_i & head_vld & ~flush_i;
   assign pop_ram  = pop_acc & ram_vld_p1;
   assign wr_en    = push_acc & ~byp_take;

   // Entries held in RAM (including a RAM-sourced head). Everything counted
   // here was written on an earlier edge, so it is safe to read this cycle.
   assign ram_cnt   = usage_q - (byp_vld_p1 ? CNT_ONE : '0);
   // Entries still waiting in RAM once this cycle's pop is taken.
   assign ram_avail = ram_cnt - (pop_ram ? CNT_ONE : '0);

   // Reload the head when it is empty or leaving and a committed entry exists.
   // Reading only committed entries keeps rd_addr away from wr_ptr_q.
   assign rd_en   = (ram_avail != '0) & (~head_vld | pop_acc) & ~flush_i;
   assign rd_addr = rd_ptr_q + (pop_ram ? PTR_ONE : '0);

   always_comb begin
      usage_nxt   = usage_q;
      wr_ptr_nxt  = wr_ptr_q;
      rd_ptr_nxt  = rd_ptr_q;
      ram_vld_nxt = ram_vld_p1;
      if (flush_i) begin
         usage_nxt   = '0;
         wr_ptr_nxt  = '0;
         rd_ptr_nxt  = '0;
         ram_vld_nxt = 1'b0;
      end else begin
         if (push_acc && !pop_acc) begin
            usage_nxt = usage_q + CNT_ONE;
         end else if (!push_acc && pop_acc) begin
            usage_nxt = usage_q - CNT_ONE;
         end
         if (wr_en) begin
            wr_ptr_nxt = wr_ptr_q + PTR_ONE;
         end
         if (pop_ram) begin
            rd_ptr_nxt = rd_ptr_q + PTR_ONE;
         end
         if (rd_en) begin
            ram_vld_nxt = 1'b1;
         end else if (pop_ram) begin
            ram_vld_nxt = 1'b0;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         usage_q    <= '0;
         ram_vld_p1 <= 1'b0;
         full_q     <= 1'b0;
         ae_q       <= 1'b1;
         af_q       <= 1'b0;
         ovf_q      <= 1'b0;
         unf_q      <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_nxt;
         rd_ptr_q   <= rd_ptr_nxt;
         usage_q    <= usage_nxt;
         ram_vld_p1 <= ram_vld_nxt;
         full_q     <= (usage_nxt == CNT_FULL);
         ae_q       <= is_almost_empty(usage_nxt);
         af_q       <= is_almost_full(usage_nxt);
         // Requests in a flush cycle are discarded silently.
         ovf_q      <= ovf_q | (push_i & full_q & ~flush_i);
         unf_q      <= unf_q | (pop_i & ~head_vld & ~flush_i);
      end
   end

   // ---- stage p0 -> p1: RAM write / head fetch ----
   fifo_v4_ram #(
      .DEPTH  (DEPTH),
      .dtype  (dtype),
      .ADDR_W (ADDR_DEPTH)
   ) u_ram (
      .clk_i   (clk_i),
      .wr_en   (wr_en),
      .wr_addr (wr_ptr_q),
      .wr_data (data_i),
      .rd_en   (rd_en),
      .rd_addr (rd_addr),
      .rd_data (ram_rdata_p1)
   );

`ifdef FIFO_V4_BYPASS_EN
   // Only when nothing is stored or in flight, so ordering is preserved.
   assign byp_take = push_acc & (usage_q == '0);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         byp_vld_p1 <= 1'b0;
      end else if (flush_i) begin
         byp_vld_p1 <= 1'b0;
      end else if (byp_take) begin
         byp_vld_p1 <= 1'b1;
      end else if (pop_acc && byp_vld_p1) begin
         byp_vld_p1 <= 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (byp_take) begin
         byp_data_p1 <= data_i;
      end
   end
`else
   assign byp_take    = 1'b0;
   assign byp_vld_p1  = 1'b0;
   assign byp_data_p1 = '0;
`endif

   // ---- stage p1: head output ----
   always_comb begin
      data_o = '0;
      if (byp_vld_p1) begin
         data_o = byp_data_p1;
      end else if (ram_vld_p1) begin
         data_o = ram_rdata_p1;
      end
   end

   assign empty_o        = ~head_vld;
   assign full_o         = full_q;
   assign almost_full_o  = af_q;
   assign almost_empty_o = ae_q;
   assign usage_o        = usage_q;
   assign overflow_o     = ovf_q;
   assign underflow_o    = unf_q;

endmodule

// File: tb/tb_fifo_v4.sv
module tb_fifo_v4;

`ifdef FIFO_V4_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic       clk_i = 1'b0;
   logic       rst_i, flush_i, push_i, pop_i;
   logic [7:0] data_i;

   logic [7:0] d8_data;
   logic       d8_full, d8_empty, d8_af, d8_ae, d8_ovf, d8_unf;
   logic [3:0] d8_usage;
   logic [7:0] d16_data;
   logic       d16_full, d16_empty, d16_af, d16_ae, d16_ovf, d16_unf;
   logic [4:0] d16_usage;

   always #5 clk_i = ~clk_i;

   fifo_v4 #(.DATA_WIDTH(8), .DEPTH(8), .AE_THRESH(2), .AF_THRESH(2)) u_dut8 (
      .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .data_i(data_i),
      .push_i(push_i), .data_o(d8_data), .pop_i(pop_i), .full_o(d8_full),
      .empty_o(d8_empty), .almost_full_o(d8_af), .almost_empty_o(d8_ae),
      .usage_o(d8_usage), .overflow_o(d8_ovf), .underflow_o(d8_unf));

   fifo_v4 #(.DATA_WIDTH(8), .DEPTH(16), .AE_THRESH(4), .AF_THRESH(4)) u_dut16 (
      .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .data_i(data_i),
      .push_i(push_i), .data_o(d16_data), .pop_i(pop_i), .full_o(d16_full),
      .empty_o(d16_empty), .almost_full_o(d16_af), .almost_empty_o(d16_ae),
      .usage_o(d16_usage), .overflow_o(d16_ovf), .underflow_o(d16_unf));

   typedef struct {
      logic [7:0] data;
      int         ready;
   } ent_t;

   typedef struct {
      bit         push;
      bit         pop;
      logic [7:0] data;
      int         exp_usage;
      bit         exp_full;
      bit         exp_ovf;
   } vec_t;

   ent_t q[$];
   int   m_usage = 0;
   bit   m_ovf = 1'b0, m_unf = 1'b0;
   int   edges = 0;
   int   n_checks = 0, n_fail = 0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic bit model_empty();
      return (q.size() == 0) || (q[0].ready > edges);
   endfunction

   // One clock: drive inputs, advance the reference model, compare after edge.
   task automatic cyc(input bit push, input bit pop, input bit flush,
                      input bit rst, input logic [7:0] d);
      bit m_empty, pacc, qacc;
      push_i = push; pop_i = pop; flush_i = flush; rst_i = rst; data_i = d;
      m_empty = model_empty();
      if (rst) begin
         q.delete(); m_usage = 0; m_ovf = 1'b0; m_unf = 1'b0;
      end else if (flush) begin
         q.delete(); m_usage = 0;
      end else begin
         pacc = push && (m_usage != 8);
         qacc = pop && !m_empty;
         if (push && m_usage == 8) m_ovf = 1'b1;
         if (pop && m_empty) m_unf = 1'b1;
         if (qacc) void'(q.pop_front());
         if (pacc) q.push_back('{data: d, ready: (BYP && m_usage == 0) ? edges + 1 : edges + 2});
         m_usage = m_usage + int'(pacc) - int'(qacc);
      end
      @(posedge clk_i);
      edges++;
      #1;
      check("usage", int'(d8_usage), m_usage);
      check("full", int'(d8_full), int'(m_usage == 8));
      check("empty", int'(d8_empty), int'(model_empty()));
      check("almost_empty", int'(d8_ae), int'(m_usage <= 2));
      check("almost_full", int'(d8_af), int'(m_usage >= 6));
      check("overflow", int'(d8_ovf), int'(m_ovf));
      check("underflow", int'(d8_unf), int'(m_unf));
      if (!model_empty()) check("data", int'(d8_data), int'(q[0].data));
   endtask

   vec_t tbl[17];

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      // Fill to full, overflow, push+pop while full, drain.
      for (int i = 0; i < 8; i++)
         tbl[i] = '{push: 1'b1, pop: 1'b0, data: 8'(8'h10 + i), exp_usage: i + 1,
                    exp_full: (i == 7), exp_ovf: 1'b0};
      tbl[8] = '{push: 1'b1, pop: 1'b0, data: 8'h99, exp_usage: 8, exp_full: 1'b1, exp_ovf: 1'b1};
      tbl[9] = '{push: 1'b1, pop: 1'b1, data: 8'h77, exp_usage: 7, exp_full: 1'b0, exp_ovf: 1'b1};
      for (int i = 10; i < 17; i++)
         tbl[i] = '{push: 1'b0, pop: 1'b1, data: 8'h00, exp_usage: 16 - i,
                    exp_full: 1'b0, exp_ovf: 1'b1};

      push_i = 1'b0; pop_i = 1'b0; flush_i = 1'b0; rst_i = 1'b1; data_i = '0;

      // Reset
      cyc(0, 0, 0, 1, 8'h00);
      cyc(0, 0, 0, 1, 8'h00);
      check("reset_data", int'(d8_data), 0);
      check("reset_empty", int'(d8_empty), 1);
      check("reset_ae", int'(d8_ae), 1);

      // Pop on empty: sticky underflow, usage unaffected
      cyc(0, 1, 0, 0, 8'h00);
      check("empty_pop_unf", int'(d8_unf), 1);
      check("empty_pop_usage", int'(d8_usage), 0);

      // Single push latency
      cyc(1, 0, 0, 0, 8'hA5);
      check("a5_usage_1cyc", int'(d8_usage), 1);
      check("a5_empty_1cyc", int'(d8_empty), BYP ? 0 : 1);
      cyc(0, 0, 0, 0, 8'h00);
      check("a5_empty_2cyc", int'(d8_empty), 0);
      check("a5_data_2cyc", int'(d8_data), 8'hA5);
      cyc(0, 1, 0, 0, 8'h00);
      check("a5_after_pop_unf", int'(d8_unf), 1);
      check("a5_after_pop_empty", int'(d8_empty), 1);

      // Table-driven fill / overflow / drain
      for (int i = 0; i < 17; i++) begin
         cyc(tbl[i].push, tbl[i].pop, 0, 0, tbl[i].data);
         check($sformatf("tbl%0d_usage", i), int'(d8_usage), tbl[i].exp_usage);
         check($sformatf("tbl%0d_full", i), int'(d8_full), int'(tbl[i].exp_full));
         check($sformatf("tbl%0d_ovf", i), int'(d8_ovf), int'(tbl[i].exp_ovf));
      end

      // Streaming across pointer wrap
      for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 8'(i));
      cyc(0, 0, 0, 0, 8'h00);
      cyc(0, 0, 0, 0, 8'h00);
      for (int i = 0; i < 24; i++) begin
         cyc(1, 1, 0, 0, 8'(4 + i));
         check("stream_usage", int'(d8_usage), 4);
         check("stream_no_gap", int'(d8_empty), 0);
      end
      for (int i = 0; i < 20 && q.size() > 0; i++) cyc(0, 1, 0, 0, 8'h00);
      check("stream_drained", q.size(), 0);

      // Flush with 5 entries and a simultaneous push
      for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 8'(8'h50 + i));
      cyc(0, 0, 0, 0, 8'h00);
      cyc(0, 0, 0, 0, 8'h00);
      cyc(1, 0, 1, 0, 8'hEE);
      check("flush_usage", int'(d8_usage), 0);
      check("flush_empty", int'(d8_empty), 1);
      cyc(1, 0, 0, 0, 8'h33);
      cyc(0, 0, 0, 0, 8'h00);
      check("post_flush_data", int'(d8_data), 8'h33);
      cyc(0, 1, 0, 0, 8'h00);
      cyc(0, 0, 0, 0, 8'h00);
      check("post_flush_empty", int'(d8_empty), 1);

      // Reset mid-operation
      for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 8'(8'hC0 + i));
      cyc(1, 0, 0, 1, 8'hCF);
      check("midrst_usage", int'(d8_usage), 0);
      check("midrst_ovf", int'(d8_ovf), 0);
      check("midrst_unf", int'(d8_unf), 0);
      check("midrst_data", int'(d8_data), 0);

      // Thresholds on the 16-deep instance
      check("thr_reset_ae", int'(d16_ae), 1);
      check("thr_reset_af", int'(d16_af), 0);
      for (int n = 1; n <= 13; n++) begin
         cyc(1, 0, 0, 0, 8'(n));
         check($sformatf("thr%0d_usage16", n), int'(d16_usage), n);
         check($sformatf("thr%0d_ae16", n), int'(d16_ae), int'(n <= 4));
         check($sformatf("thr%0d_af16", n), int'(d16_af), int'(n >= 12));
      end
      check("thr_full16", int'(d16_full), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
